divint_iter: RTL
================

Name: divint_iter

Overview:
- Parametrised sequential integer divider; successor to the fixed divide-by-constant run block.
- Takes dividend and divisor at run time and returns quotient, remainder and a divide-by-zero flag.
- Uses the same req/busy run handshake and global clock-enable as the generated method blocks.
- Instantiated by generated method FSMs in place of the fixed-latency DivInt IP.

Parameters:
- WIDTH, 32, operand/result width in bits (min 2).
- SIGNED, 1, 1 = two's-complement operands with truncation toward zero; 0 = unsigned.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- ce  in  1  clock enable; when low, all state frozen.
- i_run_req  in  1  start request; sampled only in IDLE with ce=1.
- o_run_busy  out  1  high while an operation is in flight.
- o_run_done  out  1  one-cycle (ce-qualified) completion pulse.
- i_run_dividend  in  WIDTH  dividend, captured on accepted req.
- i_run_divisor  in  WIDTH  divisor, captured on accepted req.
- o_run_quotient  out  WIDTH  registered quotient.
- o_run_remainder  out  WIDTH  registered remainder.
- o_run_div0  out  1  registered divide-by-zero flag for the last result.

Behaviour:
- Reset: state IDLE; o_run_busy=0, o_run_done=0, o_run_quotient=0, o_run_remainder=0, o_run_div0=0, iteration counter 0.
- Reset mid-operation aborts the operation and returns all outputs to their reset values.
- ce=0: no register changes. o_run_done, if high, stays high until the next ce=1 edge.
- States: IDLE, CALC, FIX, DONE.
- IDLE -> CALC on i_run_req=1 (edge E0):
  - Capture both operands.
  - If SIGNED, store the absolute values and the sign bits sq = sign(a) XOR sign(b), sr = sign(a).
  - Counter <= 0.
- CALC: one restoring radix-2 step per ce cycle.
  - Shift the partial remainder left with the next dividend MSB.
  - Subtract the divisor; commit if non-negative; set the quotient bit.
  - After WIDTH steps (counter == WIDTH-1) go to FIX.
- FIX: apply sign correction (negate quotient if sq, negate remainder if sr) and write the output registers. Next state DONE.
- DONE: o_run_done=1 for one cycle, then IDLE.
- o_run_busy: 1 in CALC, FIX and DONE; 0 in IDLE.
- Latency: req accepted at E0 -> o_run_done high in cycle E0+WIDTH+2 (34 for WIDTH=32). Outputs are valid from that cycle until the next FIX write.
- i_run_req while busy is ignored, with no queueing. Req held high across the DONE->IDLE transition starts a new operation on the first IDLE cycle.
- Divide by zero (divisor==0):
  - o_run_div0=1, quotient = all ones, remainder = dividend (original, signed value).
  - Same latency as a normal operation unless the optional feature is enabled.
- Signed overflow (SIGNED=1, dividend = minimum negative, divisor = -1): quotient = minimum negative, remainder = 0, div0=0. This is Java semantics; the natural algorithm result must be checked to match.
- Arithmetic: quotient truncates toward zero; remainder takes the sign of the dividend; |remainder| < |divisor|. Internal partial remainder is WIDTH+1 bits; no other widening.

Optional Feature:
- Macro: DIVINT_ZERO_SKIP_EN.
- Defined: a zero divisor detected in IDLE skips CALC; IDLE -> FIX -> DONE, so done arrives at E0+2. Results are identical to the slow path.
- Undefined: a zero divisor runs the full WIDTH CALC cycles. The detection logic is removed and only FIX applies the div0 result override.

Decomposition:
- Shared package divint_pkg holds:
  - state enum (IDLE, CALC, FIX, DONE);
  - function clog2 for counter width;
  - constant DIVINT_FIX_CYCLES=2 (FIX+DONE overhead) used by callers to compute latency.
- One natural sub-module: divint_step, the combinational one-bit restoring step (partial remainder, divisor -> new remainder, quotient bit).
- FSM, counter and sign logic stay in divint_iter.

Test Plan:
- WIDTH=32, SIGNED=1: 7/2 -> q=3, r=1, div0=0; done exactly 34 cycles after the req edge; busy high cycles 1..34.
- -7/2 -> q=-3 (0xFFFFFFFD), r=-1; 7/-2 -> q=-3, r=1; 0x80000000/-1 -> q=0x80000000, r=0.
- 5/0 -> q=0xFFFFFFFF, r=5, div0=1; done at cycle 34 without the macro, cycle 2 with DIVINT_ZERO_SKIP_EN.
- WIDTH=32, SIGNED=0: 0xFFFFFFFF/2 -> q=0x7FFFFFFF, r=1; WIDTH=8: 200/7 -> q=28, r=4, done at cycle 10.
- Second req (100/3) pulsed mid-CALC -> ignored, first result unchanged. ce held low for 5 cycles mid-CALC -> done delayed by exactly 5.
- reset asserted at cycle 10 of an operation -> next cycle busy=0, outputs 0; a fresh req 9/3 then returns q=3, r=0.

Source files
------------

// File: rtl/divint_pkg.sv
// divint_pkg: shared state encoding, counter-width helper and latency overhead for divint_iter.
package divint_pkg;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  localparam int DIVINT_FIX_CYCLES = 2;
  function automatic int clog2(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/divint_step.sv
// divint_step: one restoring radix-2 step; shifts in the next dividend bit and trial-subtracts the divisor.
module divint_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] divisor,
  input  logic             bit_in,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);
  logic [WIDTH:0] sh, diff;
  always_comb begin
    sh = {rem, bit_in};
    diff = sh - {1'b0, divisor};
    q_bit = ~diff[WIDTH];
    rem_next = q_bit ? diff[WIDTH-1:0] : sh[WIDTH-1:0];
  end
endmodule

// File: rtl/divint_iter.sv
// divint_iter: iterative restoring integer divider with req/busy handshake and global clock enable.
// Define DIVINT_ZERO_SKIP_EN to bypass the iteration loop when the divisor is zero.
module divint_iter
  import divint_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int SIGNED = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ce,
  input  logic             i_run_req,
  output logic             o_run_busy,
  output logic             o_run_done,
  input  logic [WIDTH-1:0] i_run_dividend,
  input  logic [WIDTH-1:0] i_run_divisor,
  output logic [WIDTH-1:0] o_run_quotient,
  output logic [WIDTH-1:0] o_run_remainder,
  output logic             o_run_div0
);
  localparam int CW = clog2(WIDTH);
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] a_abs, b_abs, q, rem, rem_nx, a_in, b_in;
  logic sq, sr, q_bit, na, nb, skip, div0;
  assign na = SIGNED != 0 && i_run_dividend[WIDTH-1];
  assign nb = SIGNED != 0 && i_run_divisor[WIDTH-1];
  assign a_in = na ? -i_run_dividend : i_run_dividend;
  assign b_in = nb ? -i_run_divisor : i_run_divisor;
  assign div0 = b_abs == '0;
`ifdef DIVINT_ZERO_SKIP_EN
  assign skip = i_run_divisor == '0;
`else
  assign skip = 1'b0;
`endif
  assign o_run_busy = state != IDLE;
  assign o_run_done = state == DONE;
  // Dividend bits are fed MSB-first by index so a_abs survives for the div0 remainder.
  divint_step #(.WIDTH(WIDTH)) u_step (
    .rem(rem),
    .divisor(b_abs),
    .bit_in(a_abs[CW'(WIDTH-1) - cnt]),
    .rem_next(rem_nx),
    .q_bit(q_bit)
  );
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = i_run_req ? (skip ? FIX : CALC) : IDLE;
      CALC: state_nx = cnt == CW'(WIDTH-1) ? FIX : CALC;
      FIX: state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      a_abs <= '0;
      b_abs <= '0;
      q <= '0;
      rem <= '0;
      sq <= 1'b0;
      sr <= 1'b0;
      o_run_quotient <= '0;
      o_run_remainder <= '0;
      o_run_div0 <= 1'b0;
    end else if (ce) begin
      state <= state_nx;
      if (state == IDLE && i_run_req) begin
        a_abs <= a_in;
        b_abs <= b_in;
        sq <= na ^ nb;
        sr <= na;
        cnt <= '0;
        q <= '0;
        rem <= '0;
      end
      if (state == CALC) begin
        rem <= rem_nx;
        q <= {q[WIDTH-2:0], q_bit};
        cnt <= cnt + 1'b1;
      end
      if (state == FIX) begin
        o_run_quotient <= div0 ? '1 : (sq ? -q : q);
        o_run_remainder <= div0 ? (sr ? -a_abs : a_abs) : (sr ? -rem : rem);
        o_run_div0 <= div0;
      end
    end
  end
endmodule
